// File: rtl/issue_scheduler_pkg.sv
// issue_scheduler_pkg: shared unit classes, defaults and RS entry types for the issue scheduler
package issue_scheduler_pkg;
    localparam int RS_ENTRIES_DEF = 8;
    localparam int MULT_LAT_DEF = 4;
    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_MEM  = 2'd2,
        FU_RSVD = 2'd3
    } fu_e;
    typedef struct packed {
        logic valid;
        logic ready;
        fu_e  fu;
    } rs_pkt_t;
    function automatic logic is_cand(rs_pkt_t p, logic alloc, logic [1:0] cls);
        return p.valid && p.ready && !alloc && p.fu == fu_e'(cls);
    endfunction
endpackage

// File: rtl/issue_scheduler_if.sv
// issue_if: dispatch/RS status inputs and per-class grant outputs of the issue scheduler
interface issue_if
    import issue_scheduler_pkg::*;
#(
    parameter int N = RS_ENTRIES_DEF
) ();
    logic            i_flush;
    logic [N-1:0]    i_alloc;
    logic [N-1:0]    i_entry_ready;
    fu_e  [N-1:0]    i_entry_fu;
    logic            i_alu_stall;
    logic            i_mem_done;
    logic [N-1:0]    o_alu_gnt;
    logic [N-1:0]    o_mult_gnt;
    logic [N-1:0]    o_mem_gnt;
    logic [N-1:0]    o_issue_clear;
    logic            o_mult_busy;
    logic            o_mem_busy;
    modport slave (
        input  i_flush, i_alloc, i_entry_ready, i_entry_fu, i_alu_stall, i_mem_done,
        output o_alu_gnt, o_mult_gnt, o_mem_gnt, o_issue_clear, o_mult_busy, o_mem_busy
    );
    modport master (
        output i_flush, i_alloc, i_entry_ready, i_entry_fu, i_alu_stall, i_mem_done,
        input  o_alu_gnt, o_mult_gnt, o_mem_gnt, o_issue_clear, o_mult_busy, o_mem_busy
    );
endinterface

// File: rtl/issue_scheduler_age_select.sv
// age_select: picks the one candidate that no other candidate is older than
module age_select
    import issue_scheduler_pkg::*;
#(
    parameter int N = RS_ENTRIES_DEF
) (
    input  logic [N-1:0]         i_cand,
    input  logic [N-1:0][N-1:0]  i_older,
    output logic [N-1:0]         o_sel
);
    // entry i wins when it is a candidate and no other candidate j has older[j][i]
    always_comb begin
        for (int i = 0; i < N; i++) begin
            o_sel[i] = i_cand[i];
            for (int j = 0; j < N; j++)
                if (j != i && i_cand[j] && i_older[j][i])
                    o_sel[i] = 1'b0;
        end
    end
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: oldest-first per-class issue select with multiplier and memory occupancy tracking
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int RS_ENTRIES = RS_ENTRIES_DEF,
    parameter int MULT_LAT   = MULT_LAT_DEF
) (
    input logic    i_clk,
    input logic    i_rst_n,
    issue_if.slave bus
);
    localparam int N  = RS_ENTRIES;
    localparam int CW = $clog2(MULT_LAT);

    logic [N-1:0]         r_valid;
    logic [N-1:0][N-1:0]  r_older;
    logic [CW-1:0]        r_mult_cnt;
    logic                 r_mem_busy;
    logic [N-1:0]         w_valid_nxt;
    logic [N-1:0][N-1:0]  w_older_nxt;
    logic [2:0][N-1:0]    w_cand;
    logic [2:0][N-1:0]    w_sel;
    logic [N-1:0]         w_alu_gnt;
    logic [N-1:0]         w_mult_gnt;
    logic [N-1:0]         w_mem_gnt;
    logic [N-1:0]         w_clear;
    logic                 w_mult_busy;

    // per-class candidates: tracked, operands ready, matching class, not rewritten this cycle
    always_comb begin
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < N; i++)
                w_cand[c][i] = is_cand('{valid: r_valid[i], ready: bus.i_entry_ready[i], fu: bus.i_entry_fu[i]},
                                       bus.i_alloc[i], 2'(c));
    end

    for (genvar c = 0; c < 3; c++) begin : g_sel
        age_select #(.N(N)) u_sel (
            .i_cand  (w_cand[c]),
            .i_older (r_older),
            .o_sel   (w_sel[c])
        );
    end

    assign w_mult_busy = r_mult_cnt != '0;
    assign w_alu_gnt   = (bus.i_alu_stall || bus.i_flush) ? '0 : w_sel[0];
    assign w_mult_gnt  = (w_mult_busy || bus.i_flush) ? '0 : w_sel[1];
    assign w_mem_gnt   = (r_mem_busy || bus.i_flush) ? '0 : w_sel[2];
    assign w_clear     = w_alu_gnt | w_mult_gnt | w_mem_gnt;

    assign bus.o_alu_gnt     = w_alu_gnt;
    assign bus.o_mult_gnt    = w_mult_gnt;
    assign bus.o_mem_gnt     = w_mem_gnt;
    assign bus.o_issue_clear = w_clear;
    assign bus.o_mult_busy   = w_mult_busy;
    assign bus.o_mem_busy    = r_mem_busy;

    // next tracking state: issued entries retire, a new alloc becomes youngest, flush wipes everything
    always_comb begin
        w_valid_nxt = (r_valid & ~w_clear) | bus.i_alloc;
        w_older_nxt = r_older;
        for (int i = 0; i < N; i++)
            if (bus.i_alloc[i])
                for (int j = 0; j < N; j++) begin
                    w_older_nxt[i][j] = 1'b0;
                    if (j != i)
                        w_older_nxt[j][i] = r_valid[j];
                end
        if (bus.i_flush) begin
            w_valid_nxt = '0;
            w_older_nxt = '0;
        end
    end

    // entry valid bits and age matrix
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            r_older <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_older <= w_older_nxt;
        end
    end

    // multiplier occupancy countdown, loaded on each multiply issue
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_mult_cnt <= '0;
        else if (bus.i_flush)
            r_mult_cnt <= '0;
        else if (|w_mult_gnt)
            r_mult_cnt <= CW'(MULT_LAT - 1);
        else if (w_mult_busy)
            r_mult_cnt <= r_mult_cnt - CW'(1);
    end

    // memory op in flight; only completion clears it, a squash does not
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_mem_busy <= 1'b0;
        else if (|w_mem_gnt)
            r_mem_busy <= 1'b1;
        else if (bus.i_mem_done)
            r_mem_busy <= 1'b0;
    end
endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 Parameter RS_ENTRIES, default 8, number of reservation-station entries scheduled.
REQ-002 Parameter MULT_LAT, default 4, cycles the iterative multiplier stays occupied per issue (minimum 2).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  branch-mispredict squash; clears all entry tracking.
REQ-006 alloc  input  RS_ENTRIES  one-hot-or-zero; entry written by dispatch this cycle.
REQ-007 entry_ready  input  RS_ENTRIES  entry holds both operands.
REQ-008 entry_fu  input  RS_ENTRIES x 2  per-entry unit class: 0 ALU, 1 MULT, 2 MEM, 3 reserved (never granted).
REQ-009 alu_stall  input  1  execute stage cannot accept an ALU op this cycle.
REQ-010 mem_done  input  1  single-cycle pulse; outstanding memory op completed.
REQ-011 alu_gnt, mult_gnt, mem_gnt  output  RS_ENTRIES each  one-hot-or-zero grant per unit class.
REQ-012 issue_clear  output  RS_ENTRIES  OR of the three grants; RS deasserts ready on these entries.
REQ-013 mult_busy, mem_busy  output  1 each  unit occupied.

Function
REQ-014 Internal valid vector: bit set on alloc, cleared on grant of that entry or on flush.
REQ-015 Internal age matrix: older[i][j]=1 means entry i allocated before entry j; on alloc of i, row i cleared and older[j][i] set for every valid j≠i.
REQ-016 Candidate for class C: valid & entry_ready & entry_fu==C & not allocated this cycle.
REQ-017 Each grant selects the oldest candidate of its class per the age matrix; grants are combinational from registered state and inputs, zero-cycle latency.
REQ-018 ALU grant forced zero while alu_stall is high.
REQ-019 MULT grant forced zero while mult_busy; on a MULT grant a counter loads MULT_LAT-1 and mult_busy is high for exactly the following MULT_LAT-1 cycles, so MULT grants are at least MULT_LAT cycles apart.
REQ-020 MEM grant forced zero while mem_busy (registered); mem_busy sets on MEM grant, clears on mem_done; a grant in the cycle of mem_done is not allowed.
REQ-021 At most one grant per class per cycle; up to three grants total per cycle to distinct entries.
REQ-022 Alloc and grant of the same index in one cycle: alloc wins, entry valid and youngest.
REQ-023 Flush: next cycle valid vector and age matrix zero, mult counter zero; grants in the flush cycle are suppressed; alloc in the flush cycle is dropped.
REQ-024 mem_busy survives flush and clears only on mem_done (memory op still in flight).
REQ-025 mem_done while mem_busy low is ignored.

Reset
REQ-026 Reset asserted: valid, age matrix, mult counter, mem_busy cleared; all grant, issue_clear and busy outputs 0 while reset low and first cycle after.
REQ-027 Reset asserted mid-multiply or mid-memory op aborts it; no pending state survives.

Structure
REQ-028 Unit-class enumeration (FU_ALU, FU_MULT, FU_MEM, FU_RSVD), RS_ENTRIES and MULT_LAT defaults live in the shared package beside the RS packet typedefs.
REQ-029 One sub-module, age_select: given candidate vector and age matrix returns one-hot oldest; instantiated three times.

Verification
REQ-030 Alloc entries 5,2,7 (ALU, one per cycle), all ready in cycle 4 -> alu_gnt 5, then 2, then 7 on consecutive cycles.
REQ-031 Two MULT entries ready, MULT_LAT=4 -> first grant cycle N, mult_busy high N+1..N+3, second grant cycle N+4.
REQ-032 MEM grant cycle N, flush N+2, mem_done N+5 -> mem_busy high N+1..N+5, no MEM grant before N+6 even with ready MEM entry.
REQ-033 ALU, MULT, MEM entries all ready same cycle, units idle -> three distinct grants that cycle, issue_clear shows three bits.
REQ-034 alu_stall high 3 cycles with ALU entry ready -> no alu_gnt during stall, grant first cycle stall low.
REQ-035 Reset low during mult_busy -> mult_busy, grants zero; after release, new MULT entry granted without waiting.
